parallel_uart_tx: RTL and testbench
===================================

# parallel_uart_tx

Serial transmitter fed by the memory-mapped parallel output port at address 0xFF. Each byte the processor stores to that port is also written into a small FIFO in this block. The block then sends it as an 8N1 asynchronous serial frame on `tx`. The FIFO absorbs bursts of single-cycle stores, so software can write several bytes back to back without polling.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, 4: FIFO entries; must be a power of two, ≥ 2.

- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `wr_en`  input  1  write strobe; driven by the output port's own write qualifier (`we` and address == 8'hFF); high for one cycle per store.
- `wr_data`  input  8  byte being stored (the port's register data); sampled when `wr_en` is high.
- `tx`  output  1  serial line; idle high.
- `busy`  output  1  high while the FIFO is non-empty or a frame is in progress.
- `full`  output  1  high when the FIFO holds `FIFO_DEPTH` entries.
- `overflow`  output  1  sticky; set when a write is dropped; cleared only by reset.

## Operation
- FIFO:
  - Circular buffer with write pointer, read pointer and occupancy count, each sized for `FIFO_DEPTH`.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Push:
  - A push occurs when `wr_en` is high and either `full` is low, or a pop happens on the same edge.
  - Push and pop on the same edge leave the count unchanged.
- Dropped write:
  - `wr_en` high while `full` is high and no pop on that edge: the byte is discarded and `overflow` is set to 1.
  - FIFO contents are unchanged.
- FSM states:
  - IDLE: `tx` = 1. If the count is > 0, pop the head entry into an 8-bit shift register, load the baud counter, and go to START.
  - START: `tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `tx` = shift register bit 0, i.e. LSB first. Each bit lasts `CLKS_PER_BIT` cycles; then shift right and increment the bit index. After bit 7, go to STOP.
  - STOP: `tx` = 1 for `CLKS_PER_BIT` cycles. At the end of STOP, if the count is > 0, pop and go straight to START (no idle gap); otherwise go to IDLE.
- Baud counter:
  - Loaded with `CLKS_PER_BIT-1` on entry to each bit and decrements each cycle.
  - A bit ends on the cycle the counter reads 0.
  - Width is ceil(log2(`CLKS_PER_BIT`)) bits.
- Outputs:
  - `tx` is registered, so no glitches.
  - `busy` = (state ≠ IDLE) or (count ≠ 0).
  - `full` = (count == `FIFO_DEPTH`).

## Timing
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - `tx` = 1, `busy` = 0, `full` = 0, `overflow` = 0.
  - FIFO emptied; state IDLE; pending bytes discarded.
- Latency: a byte written at edge N, with the FIFO empty and the FSM in IDLE, is popped at edge N+1. `tx` falls immediately after edge N+1.
- Frame length: exactly 10×`CLKS_PER_BIT` cycles (start, 8 data, stop).
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- `wr_en` held high for several consecutive cycles: each cycle is a separate push.

## Test plan
- Single byte, `CLKS_PER_BIT`=4: write 0xA5 once.
  - `tx` sequence, each level held 4 cycles: 0, 1,0,1,0,0,1,0,1, 1. That is 40 cycles.
  - `busy` high from the edge after the write until the end of the stop bit, then low.
- Back-to-back: write 0x00 then 0xFF on consecutive cycles.
  - Two contiguous 40-cycle frames with no idle cycle between them.
  - Frame 1 data bits all 0; frame 2 data bits all 1.
- Overflow, `FIFO_DEPTH`=4: write 0x01 to 0x06 on six consecutive cycles.
  - Bytes 0x01 to 0x05 are transmitted in order; 0x06 is never seen on `tx`.
  - `overflow` = 1 from the sixth write onward.
  - `full` = 1 after the fifth write until the next pop.
- Push on a full FIFO at the pop edge: fill to 4 entries and hold `wr_en` at the stop→start boundary.
  - The byte is accepted, count stays 4, `overflow` stays 0.
- Reset mid-frame: assert `rst_n` = 0 during DATA bit 3 with 2 bytes queued.
  - `tx` = 1 and `busy` = 0 immediately, with no further frames.
  - After release, a new write of 0x3C transmits correctly.
- Idle stability: run 100 cycles with no writes after reset.
  - `tx` = 1, `busy` = 0, `full` = 0, `overflow` = 0 throughout.

Source files
------------

// File: rtl/parallel_uart_tx_if.sv
// Byte-store port between the processor's 0xFF output register and the UART transmitter.
// Latency: none, wires only.
// Backpressure: none on the bus; the slave reports full/overflow and drops writes it cannot take.
interface parallel_uart_tx_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx;
    logic       busy;
    logic       full;
    logic       overflow;

    // Processor / output-port side
    modport master (
        output wr_en, wr_data,
        input  tx, busy, full, overflow
    );

    // Transmitter side
    modport slave (
        input  wr_en, wr_data,
        output tx, busy, full, overflow
    );
endinterface

// File: rtl/parallel_uart_tx.sv
// 8N1 serial transmitter fed by single-cycle byte stores through a small circular FIFO.
// Latency: a byte written into an empty FIFO while idle is popped next edge; tx falls right after it.
// Backpressure: none; a store to a full FIFO without a same-edge pop is dropped and sets sticky overflow.
module parallel_uart_tx #(
    parameter int CLKS_PER_BIT = 16,   // >= 2
    parameter int FIFO_DEPTH   = 4     // power of two, >= 2
) (
    input  logic               clk,
    input  logic               rst_n,
    parallel_uart_tx_if.slave  port_if
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t         state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;

    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           overflow_q;
    logic [7:0]     mem_q [FIFO_DEPTH];

    logic           full;
    logic           bit_end;
    logic           pop;
    logic           push;
    logic [7:0]     head;

    assign full    = (count_q == DEPTH_C);
    assign bit_end = (baud_q == '0);
    assign head    = mem_q[rd_ptr_q];
    // Pops happen only when the FSM starts a frame: from idle, or at the last stop-bit cycle.
    assign pop     = (count_q != '0) &&
                     ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));
    // A full FIFO still accepts a store when the head leaves on the same edge.
    assign push    = port_if.wr_en && (!full || pop);

    // FIFO pointers, occupancy and the sticky drop flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
            if (port_if.wr_en && !push) overflow_q <= 1'b1;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= port_if.wr_data;
    end

    // FSM state, baud counter, shift register and registered line output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    // Next-state: each bit lasts until the baud counter reads zero
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    shift_d = head;
                    baud_d  = BAUD_LOAD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_d    = BAUD_LOAD;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d    = BAUD_LOAD;
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (pop) begin
                        // Chain straight into the next start bit, no idle gap
                        shift_d = head;
                        baud_d  = BAUD_LOAD;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line level for the next cycle, derived from the next state so tx is a clean flop
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign port_if.tx       = tx_q;
    assign port_if.busy     = (state_q != S_IDLE) || (count_q != '0);
    assign port_if.full     = full;
    assign port_if.overflow = overflow_q;

endmodule

// File: tb/tb_parallel_uart_tx.sv
// Self-checking bench for parallel_uart_tx: table of single-byte frames plus corner sequences.
// Expected frames are queued at write time and compared when the line monitor decodes a frame.
// All DUT sampling happens on the falling clock edge.
module tb_parallel_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    parallel_uart_tx_if bus ();

    parallel_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .port_if (bus)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;
    int         w_cyc = 0;
    logic [9:0] exp_q [$];
    int         starts [$];

    bit         mon_act = 1'b0;
    int         mon_cnt = 0;
    bit         mon_bad = 1'b0;
    logic [9:0] mon_bits;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;        // {stop, data[7:0], start}, bit 0 sent first
        int         busy_cycles;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [9:0] frame_of(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    // cycle counter: value read at a falling edge = number of rising edges so far
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // line monitor: every cycle of every bit must hold the level seen in that bit's first cycle
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (bus.tx == 1'b0) begin
                mon_act  = 1'b1;
                mon_cnt  = 1;
                mon_bad  = 1'b0;
                mon_bits = '0;
                starts.push_back(cyc);
            end
        end else begin
            if (mon_cnt % CPB == 0) mon_bits[mon_cnt / CPB] = bus.tx;
            else if (bus.tx !== mon_bits[mon_cnt / CPB]) mon_bad = 1'b1;
            mon_cnt++;
            if (mon_cnt == FRAME) begin
                mon_act = 1'b0;
                check("frame_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("frame_bits", mon_bits, exp_q.pop_front());
                check("bit_width_stable", mon_bad, 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run exceeded time limit, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        bus.wr_en = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {bus.tx, bus.busy, bus.full, bus.overflow}, 4'b1000);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.delete();
        starts.delete();
    endtask

    task automatic write_byte(input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
        w_cyc     = cyc;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!bus.busy && !mon_act) begin
                done = 1'b1;
                break;
            end
        end
        check(name, done, 1);
    endtask

    task automatic wait_until_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        int nb;
        int bad;
        int w1;

        vecs[0] = '{data: 8'hA5, frame: 10'h34A, busy_cycles: 41};
        vecs[1] = '{data: 8'h5A, frame: 10'h2B4, busy_cycles: 41};
        vecs[2] = '{data: 8'h01, frame: 10'h202, busy_cycles: 41};
        vecs[3] = '{data: 8'h80, frame: 10'h300, busy_cycles: 41};
        vecs[4] = '{data: 8'hFF, frame: 10'h3FE, busy_cycles: 41};

        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        apply_reset();

        // idle stability
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if ({bus.tx, bus.busy, bus.full, bus.overflow} !== 4'b1000) bad++;
            @(negedge clk);
        end
        check("idle_stable_bad_cycles", bad, 0);
        check("idle_no_frames", starts.size(), 0);

        // single-byte frames from the table
        for (int i = 0; i < 5; i++) begin
            starts.delete();
            exp_q.push_back(vecs[i].frame);
            write_byte(vecs[i].data);
            nb = 0;
            for (int k = 0; k < 200 && bus.busy; k++) begin
                nb++;
                @(negedge clk);
            end
            check("busy_cycles", nb, vecs[i].busy_cycles);
            check("tx_latency", (starts.size() > 0) ? starts[0] - w_cyc : -1, 1);
            check("tx_idle_after", bus.tx, 1);
            check("queue_drained", exp_q.size(), 0);
        end

        // back-to-back 0x00 then 0xFF
        starts.delete();
        exp_q.push_back(10'h200);
        exp_q.push_back(10'h3FE);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h00;
        @(negedge clk);
        w1          = cyc;
        bus.wr_data = 8'hFF;
        @(negedge clk);
        bus.wr_en = 1'b0;
        wait_idle("b2b_idle_timeout", 200);
        check("b2b_frame_count", starts.size(), 2);
        if (starts.size() == 2) begin
            check("b2b_first_latency", starts[0] - w1, 1);
            check("b2b_gap", starts[1] - starts[0], FRAME);
        end
        check("b2b_queue_drained", exp_q.size(), 0);

        // overflow: six stores into a depth-4 FIFO, sixth dropped
        apply_reset();
        for (int d = 1; d <= 5; d++) exp_q.push_back(frame_of(8'(d)));
        for (int d = 1; d <= 6; d++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(d);
            @(negedge clk);
            if (d == 1) w1 = cyc;
            check("ovf_full_after_write", bus.full, d >= 5);
            check("ovf_flag_after_write", bus.overflow, d == 6);
        end
        bus.wr_en = 1'b0;
        wait_until_cyc(w1 + 40);
        check("ovf_full_before_pop", bus.full, 1);
        @(negedge clk);
        check("ovf_full_after_pop", bus.full, 0);
        check("ovf_sticky", bus.overflow, 1);
        wait_idle("ovf_idle_timeout", 400);
        check("ovf_sticky_end", bus.overflow, 1);
        check("ovf_queue_drained", exp_q.size(), 0);

        // store into a full FIFO on the pop edge is accepted
        apply_reset();
        for (int d = 0; d < 5; d++) exp_q.push_back(frame_of(8'h11 + 8'(d)));
        exp_q.push_back(frame_of(8'h5A));
        for (int d = 0; d < 5; d++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'h11 + 8'(d);
            @(negedge clk);
            if (d == 0) w1 = cyc;
        end
        bus.wr_en = 1'b0;
        wait_until_cyc(w1 + 40);
        check("popedge_full_before", bus.full, 1);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h5A;
        @(negedge clk);
        bus.wr_en = 1'b0;
        check("popedge_full_after", bus.full, 1);
        check("popedge_no_overflow", bus.overflow, 0);
        wait_idle("popedge_idle_timeout", 500);
        check("popedge_overflow_end", bus.overflow, 0);
        check("popedge_queue_drained", exp_q.size(), 0);

        // reset during data bit 3 with two bytes queued
        apply_reset();
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h81;
        @(negedge clk);
        w1          = cyc;
        bus.wr_data = 8'h82;
        @(negedge clk);
        bus.wr_data = 8'h83;
        @(negedge clk);
        bus.wr_en = 1'b0;
        wait_until_cyc(w1 + 18);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_outputs", {bus.tx, bus.busy, bus.full, bus.overflow}, 4'b1000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        starts.delete();
        exp_q.delete();
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad++;
        end
        check("midrst_quiet_bad_cycles", bad, 0);
        check("midrst_no_frames", starts.size(), 0);
        exp_q.push_back(10'h278);
        write_byte(8'h3C);
        wait_idle("midrst_idle_timeout", 200);
        check("midrst_new_latency", (starts.size() > 0) ? starts[0] - w_cyc : -1, 1);
        check("midrst_queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
